// File: rtl/uart_rx_pkt_ctrl.sv
// Packet framer behind the byte-level UART receiver: parses [HEADER][LEN][PAYLOAD][CSUM],
// verifies the XOR checksum and holds good packets for a valid/ready consumer.
module uart_rx_pkt_ctrl #(
    parameter logic [7:0] HEADER  = 8'hA5,
    parameter int         MAX_LEN = 8,
    parameter int         TIMEOUT = 50000
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   rx_finish,
    input  logic                   rx_error,
    input  logic [7:0]             rx_data,
    input  logic                   pkt_ready,
    output logic                   pkt_valid,
    output logic [3:0]             pkt_len,
    output logic [8*MAX_LEN-1:0]   pkt_payload,
    output logic                   busy,
    output logic                   err_csum,
    output logic                   err_len,
    output logic                   err_frame,
    output logic                   err_timeout,
    output logic                   err_overrun
);

    typedef enum logic [2:0] {IDLE, LEN, PAYLOAD, CSUM, HOLD} state_t;

    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

    state_t      state, state_nx;
    logic [3:0]  idx;
    logic [7:0]  acc;
    logic [15:0] tmo_cnt;
    logic        byte_evt, timed, len_ok, tmo_clr;
    logic        clr_pkt, ld_len, st_byte;
    logic        csum_nx, len_nx, frame_nx, tmo_nx, ovr_nx;

    // rx_error wins over a simultaneous rx_finish
    assign byte_evt  = rx_finish && !rx_error;
    assign timed     = (state == LEN) || (state == PAYLOAD) || (state == CSUM);
    assign len_ok    = (rx_data != 8'd0) && (rx_data <= 8'(MAX_LEN));
    assign tmo_clr   = byte_evt || (state_nx != state);
    assign pkt_valid = (state == HOLD);
    assign busy      = (state != IDLE);

    always_comb begin
        state_nx = state;
        clr_pkt  = 1'b0;
        ld_len   = 1'b0;
        st_byte  = 1'b0;
        csum_nx  = 1'b0;
        len_nx   = 1'b0;
        frame_nx = 1'b0;
        tmo_nx   = 1'b0;
        ovr_nx   = 1'b0;
        case (state)
            IDLE: begin
                if (byte_evt && rx_data == HEADER) begin
                    clr_pkt  = 1'b1;
                    state_nx = LEN;
                end
            end
            LEN: begin
                if (byte_evt) begin
                    if (len_ok) begin
                        ld_len   = 1'b1;
                        state_nx = PAYLOAD;
                    end else begin
                        len_nx   = 1'b1;
                        state_nx = IDLE;
                    end
                end
            end
            PAYLOAD: begin
                if (byte_evt) begin
                    st_byte = 1'b1;
                    if (idx == pkt_len - 4'd1) state_nx = CSUM;
                end
            end
            CSUM: begin
                if (byte_evt) begin
                    if (rx_data == acc) begin
                        state_nx = HOLD;
                    end else begin
                        csum_nx  = 1'b1;
                        state_nx = IDLE;
                    end
                end
            end
            HOLD: begin
                // every byte arriving here is lost, even on the handshake cycle
                if (byte_evt)  ovr_nx   = 1'b1;
                if (pkt_ready) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
        if (timed) begin
            if (rx_error) begin
                frame_nx = 1'b1;
                state_nx = IDLE;
            end else if (!byte_evt && tmo_cnt == TMO_LAST) begin
                tmo_nx   = 1'b1;
                state_nx = IDLE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            idx         <= '0;
            acc         <= '0;
            tmo_cnt     <= '0;
            pkt_len     <= '0;
            pkt_payload <= '0;
            err_csum    <= 1'b0;
            err_len     <= 1'b0;
            err_frame   <= 1'b0;
            err_timeout <= 1'b0;
            err_overrun <= 1'b0;
        end else begin
            state       <= state_nx;
            err_csum    <= csum_nx;
            err_len     <= len_nx;
            err_frame   <= frame_nx;
            err_timeout <= tmo_nx;
            err_overrun <= ovr_nx;
            if (tmo_clr)    tmo_cnt <= '0;
            else if (timed) tmo_cnt <= tmo_cnt + 16'd1;
            if (clr_pkt) begin
                pkt_payload <= '0;
                idx         <= '0;
                acc         <= '0;
            end
            if (ld_len) begin
                pkt_len <= rx_data[3:0];
                acc     <= rx_data;
            end
            if (st_byte) begin
                acc <= acc ^ rx_data;
                idx <= idx + 4'd1;
                for (int i = 0; i < MAX_LEN; i++)
                    if (idx == 4'(i)) pkt_payload[8*i +: 8] <= rx_data;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_pkt_ctrl.sv
// Bench for uart_rx_pkt_ctrl: directed packet scenarios with literal expectations, then
// randomized byte traffic checked every cycle against a byte-list reference model.
module tb_uart_rx_pkt_ctrl;

    localparam logic [7:0] HDR = 8'hA5;
    localparam int         ML  = 8;
    localparam int         TMO = 40;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          rx_finish = 1'b0;
    logic          rx_error = 1'b0;
    logic [7:0]    rx_data = 8'h00;
    logic          pkt_ready;
    logic          pkt_valid;
    logic [3:0]    pkt_len;
    logic [8*ML-1:0] pkt_payload;
    logic          busy, err_csum, err_len, err_frame, err_timeout, err_overrun;

    int  n_tests = 0;
    int  n_fail  = 0;
    bit  chk_en  = 1'b0;
    bit  rand_ready = 1'b0;
    bit  ready_force = 1'b1;

    uart_rx_pkt_ctrl #(.HEADER(HDR), .MAX_LEN(ML), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst), .rx_finish(rx_finish), .rx_error(rx_error), .rx_data(rx_data),
        .pkt_ready(pkt_ready), .pkt_valid(pkt_valid), .pkt_len(pkt_len),
        .pkt_payload(pkt_payload), .busy(busy), .err_csum(err_csum), .err_len(err_len),
        .err_frame(err_frame), .err_timeout(err_timeout), .err_overrun(err_overrun)
    );

    always #5 clk = ~clk;

    initial begin
        pkt_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            pkt_ready = rand_ready ? ($urandom % 3 != 0) : ready_force;
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: tracks the bytes of the packet in flight as a list
    bit          m_in_pkt, m_hold;
    int          frame[$];
    int          quiet;
    logic        m_valid, m_busy, m_ecsum, m_elen, m_eframe, m_etmo, m_eovr;
    logic [3:0]  m_len;
    logic [63:0] m_pay;

    always @(posedge clk) begin
        bit ev;
        int x;
        ev = rx_finish && !rx_error;
        {m_ecsum, m_elen, m_eframe, m_etmo, m_eovr} = '0;
        if (rst) begin
            m_in_pkt = 0; m_hold = 0; frame.delete(); quiet = 0;
            m_len = '0; m_pay = '0;
        end else if (m_hold) begin
            if (ev) m_eovr = 1;
            if (pkt_ready) m_hold = 0;
        end else if (!m_in_pkt) begin
            if (ev && rx_data == HDR) begin
                m_in_pkt = 1; frame.delete(); quiet = 0;
            end
        end else if (rx_error) begin
            m_eframe = 1; m_in_pkt = 0;
        end else if (ev) begin
            frame.push_back(int'(rx_data));
            quiet = 0;
            if (frame.size() == 1 && (frame[0] == 0 || frame[0] > ML)) begin
                m_elen = 1; m_in_pkt = 0;
            end else if (frame.size() == frame[0] + 2) begin
                x = 0;
                for (int i = 0; i < frame.size() - 1; i++) x = x ^ frame[i];
                if (x == frame[frame.size()-1]) begin
                    m_hold = 1;
                    m_len  = 4'(frame[0]);
                    m_pay  = '0;
                    for (int i = 1; i <= frame[0]; i++) m_pay[8*(i-1) +: 8] = 8'(frame[i]);
                end else begin
                    m_ecsum = 1;
                end
                m_in_pkt = 0;
            end
        end else begin
            quiet++;
            if (quiet == TMO) begin
                m_etmo = 1; m_in_pkt = 0;
            end
        end
        m_valid = m_hold;
        m_busy  = m_in_pkt || m_hold;
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("pkt_valid", pkt_valid, m_valid);
            chk("busy", busy, m_busy);
            chk("err_csum", err_csum, m_ecsum);
            chk("err_len", err_len, m_elen);
            chk("err_frame", err_frame, m_eframe);
            chk("err_timeout", err_timeout, m_etmo);
            chk("err_overrun", err_overrun, m_eovr);
            if (m_valid) begin
                chk("pkt_len", pkt_len, m_len);
                chk("pkt_payload", pkt_payload, m_pay);
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(posedge clk); #1;
        rx_finish = 1'b1; rx_data = b;
        @(posedge clk); #1;
        rx_finish = 1'b0; rx_data = 8'($urandom);
    endtask

    task automatic send_err();
        @(posedge clk); #1;
        rx_error = 1'b1; rx_finish = 1'($urandom % 2); rx_data = 8'($urandom);
        @(posedge clk); #1;
        rx_error = 1'b0; rx_finish = 1'b0;
    endtask

    task automatic do_rst();
        @(posedge clk); #1; rst = 1'b1;
        @(posedge clk); #1; rst = 1'b0;
    endtask

    task automatic send_pkt(input int len, input bit bad, input int gap);
        logic [7:0] x, b;
        send_byte(HDR);
        idle($urandom_range(0, gap));
        send_byte(8'(len));
        x = 8'(len);
        for (int i = 0; i < len; i++) begin
            b = 8'($urandom);
            x = x ^ b;
            send_byte(b);
            idle($urandom_range(0, gap));
        end
        send_byte(bad ? x ^ (8'd1 << ($urandom % 8)) : x);
    endtask

    task automatic check_idle_outputs(input string nm);
        chk({nm, "_valid"}, pkt_valid, 0);
        chk({nm, "_busy"}, busy, 0);
        chk({nm, "_errs"}, {err_csum, err_len, err_frame, err_timeout, err_overrun}, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt, k;
        idle(2); #1;
        rst = 1'b0;
        chk_en = 1'b1;
        check_idle_outputs("reset");
        chk("reset_len", pkt_len, 0);
        chk("reset_payload", pkt_payload, 0);

        // good packet, consumer ready
        send_byte(HDR); send_byte(8'h03); send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
        send_byte(8'h03);
        chk("t1_valid", pkt_valid, 1);
        chk("t1_len", pkt_len, 3);
        chk("t1_payload", pkt_payload, 64'h0000_0000_0033_2211);
        idle(2);

        // checksum mismatch
        send_byte(HDR); send_byte(8'h03); send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
        send_byte(8'h04);
        chk("t2_err_csum", err_csum, 1);
        chk("t2_valid", pkt_valid, 0);
        chk("t2_busy", busy, 0);
        @(posedge clk); #1;
        chk("t2_pulse_end", err_csum, 0);

        // bad lengths
        send_byte(HDR); send_byte(8'h00);
        chk("t3_len0", err_len, 1);
        send_byte(HDR); send_byte(8'h09);
        chk("t3_len9", err_len, 1);
        chk("t3_busy", busy, 0);
        send_byte(HDR); send_byte(8'h01); send_byte(8'hC3); send_byte(8'hC2);
        chk("t3_accept", pkt_valid, 1);
        chk("t3_payload", pkt_payload, 64'hC3);
        idle(2);

        // inter-byte timeout
        send_byte(HDR); send_byte(8'h02); send_byte(8'h55);
        cnt = 0;
        for (int i = 0; i < 2 * TMO; i++) begin
            @(posedge clk); #1;
            if (err_timeout) cnt++;
        end
        chk("t4_tmo_pulses", cnt, 1);
        chk("t4_busy", busy, 0);
        send_byte(HDR); send_byte(8'h01); send_byte(8'h7E); send_byte(8'h7F);
        chk("t4_valid", pkt_valid, 1);
        chk("t4_payload", pkt_payload, 64'h7E);
        idle(2);

        // overrun while holding
        ready_force = 1'b0;
        idle(2);
        send_byte(HDR); send_byte(8'h02); send_byte(8'h10); send_byte(8'h20); send_byte(8'h32);
        chk("t5_valid", pkt_valid, 1);
        send_byte(8'h5A);
        chk("t5_overrun", err_overrun, 1);
        chk("t5_payload", pkt_payload, 64'h2010);
        send_byte(HDR);
        chk("t5_hdr_overrun", err_overrun, 1);
        chk("t5_still_valid", pkt_valid, 1);
        ready_force = 1'b1;
        k = 0;
        while (pkt_valid && k < 6) begin
            @(posedge clk); #1; k++;
        end
        chk("t5_handshake", pkt_valid, 0);
        chk("t5_busy", busy, 0);

        // frame error and reset mid-payload
        send_byte(HDR); send_byte(8'h04); send_byte(8'h01); send_byte(8'h02);
        send_err();
        chk("t6_frame", err_frame, 1);
        chk("t6_busy", busy, 0);
        send_byte(HDR); send_byte(8'h04); send_byte(8'h01); send_byte(8'h02);
        do_rst();
        check_idle_outputs("t6_rst");
        chk("t6_rst_len", pkt_len, 0);
        chk("t6_rst_payload", pkt_payload, 0);
        send_byte(HDR); send_byte(8'h02); send_byte(8'hAA); send_byte(8'hBB);
        send_byte(8'h02 ^ 8'hAA ^ 8'hBB);
        chk("t6_after_rst", pkt_valid, 1);
        chk("t6_after_payload", pkt_payload, 64'hBBAA);
        idle(3);

        // randomized traffic
        rand_ready = 1'b1;
        for (int n = 0; n < 300; n++) begin
            case ($urandom % 10)
                0, 1, 2, 3, 4: send_pkt($urandom_range(1, ML), 1'b0, $urandom_range(0, 3));
                5: send_pkt($urandom_range(1, ML), 1'b1, 2);
                6: send_pkt(($urandom % 2) ? 0 : $urandom_range(ML + 1, 20), 1'b0, 1);
                7: send_byte(($urandom % 4 == 0) ? HDR : 8'($urandom));
                8: begin
                    send_byte(HDR);
                    send_byte(8'($urandom_range(1, ML)));
                    if ($urandom % 2) send_err();
                    else begin
                        idle($urandom_range(TMO - 3, TMO - 1));
                        send_byte(8'($urandom));
                    end
                end
                default: begin
                    if ($urandom % 3 == 0) do_rst();
                    else send_err();
                end
            endcase
            idle($urandom_range(0, 2));
        end
        rand_ready = 1'b0;
        ready_force = 1'b1;
        idle(TMO + 5);
        chk("end_idle_busy", busy, 0);
        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
